// File: rtl/alu_rr_scheduler_pkg.sv
// rtl/alu_rr_scheduler_pkg.sv - shared state type and default widths for the ALU round-robin scheduler
package alu_sched_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_OP_WIDTH   = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        RESPOND  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// rtl/alu_rr_scheduler_if.sv - request, ALU issue/result and response streams of the scheduler
interface alu_rr_scheduler_if
    import alu_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OP_WIDTH   = DEF_OP_WIDTH
);

    logic                  req0_tvalid;
    logic                  req0_tready;
    logic [DATA_WIDTH-1:0] req0_tdata;
    logic [OP_WIDTH-1:0]   req0_opcode;

    logic                  req1_tvalid;
    logic                  req1_tready;
    logic [DATA_WIDTH-1:0] req1_tdata;
    logic [OP_WIDTH-1:0]   req1_opcode;

    logic                  alu_tvalid;
    logic                  alu_tready;
    logic [DATA_WIDTH-1:0] alu_tdata;
    logic [OP_WIDTH-1:0]   alu_opcode;

    logic                  res_tvalid;
    logic                  res_tready;
    logic [DATA_WIDTH-1:0] res_tdata;

    logic                  rsp0_tvalid;
    logic                  rsp0_tready;
    logic [DATA_WIDTH-1:0] rsp0_tdata;

    logic                  rsp1_tvalid;
    logic                  rsp1_tready;
    logic [DATA_WIDTH-1:0] rsp1_tdata;

    // Scheduler side
    modport slave (
        input  req0_tvalid, req0_tdata, req0_opcode,
        output req0_tready,
        input  req1_tvalid, req1_tdata, req1_opcode,
        output req1_tready,
        output alu_tvalid, alu_tdata, alu_opcode,
        input  alu_tready,
        input  res_tvalid, res_tdata,
        output res_tready,
        output rsp0_tvalid, rsp0_tdata,
        input  rsp0_tready,
        output rsp1_tvalid, rsp1_tdata,
        input  rsp1_tready
    );

    // Requester/ALU side
    modport master (
        output req0_tvalid, req0_tdata, req0_opcode,
        input  req0_tready,
        output req1_tvalid, req1_tdata, req1_opcode,
        input  req1_tready,
        input  alu_tvalid, alu_tdata, alu_opcode,
        output alu_tready,
        output res_tvalid, res_tdata,
        input  res_tready,
        input  rsp0_tvalid, rsp0_tdata,
        output rsp0_tready,
        input  rsp1_tvalid, rsp1_tdata,
        output rsp1_tready
    );

endinterface

// File: rtl/alu_rr_scheduler_arb.sv
// rtl/alu_rr_scheduler_arb.sv - combinational two-request round-robin picker
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        // prio only matters on a tie; otherwise the lone requester wins
        gnt_id    = (req == 2'b11) ? prio : req[1];
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - shares one stream ALU between two requesters, one transaction in flight
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OP_WIDTH   = DEF_OP_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    alu_rr_scheduler_if.slave    bus,
    output logic                 busy,
    output logic                 grant_id,
    output logic [CNT_WIDTH-1:0] done_cnt0,
    output logic [CNT_WIDTH-1:0] done_cnt1
);

    sched_state_t          state;
    logic                  prio;
    logic                  gnt_valid;
    logic                  gnt_id;
    logic [DATA_WIDTH-1:0] op_data;
    logic [OP_WIDTH-1:0]   op_code;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  alu_valid;
    logic                  res_ready;
    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic                  req_hs;
    logic                  rsp_hs;

    rr_arbiter2 u_arb (
        .req       ({bus.req1_tvalid, bus.req0_tvalid}),
        .prio      (prio),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // tready is only raised toward a valid winner, so tready implies the handshake
    assign req_hs          = (state == IDLE) & gnt_valid;
    assign bus.req0_tready = req_hs & ~gnt_id;
    assign bus.req1_tready = req_hs & gnt_id;

    assign rsp_hs = (rsp0_valid & bus.rsp0_tready) | (rsp1_valid & bus.rsp1_tready);

    assign bus.alu_tvalid  = alu_valid;
    assign bus.alu_tdata   = op_data;
    assign bus.alu_opcode  = op_code;
    assign bus.res_tready  = res_ready;
    assign bus.rsp0_tvalid = rsp0_valid;
    assign bus.rsp0_tdata  = res_data;
    assign bus.rsp1_tvalid = rsp1_valid;
    assign bus.rsp1_tdata  = res_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            prio       <= 1'b0;
            op_data    <= '0;
            op_code    <= '0;
            res_data   <= '0;
            alu_valid  <= 1'b0;
            res_ready  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        op_data   <= gnt_id ? bus.req1_tdata  : bus.req0_tdata;
                        op_code   <= gnt_id ? bus.req1_opcode : bus.req0_opcode;
                        grant_id  <= gnt_id;
                        alu_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.alu_tready) begin
                        alu_valid <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (bus.res_tvalid) begin
                        res_ready  <= 1'b0;
                        res_data   <= bus.res_tdata;
                        rsp0_valid <= ~grant_id;
                        rsp1_valid <= grant_id;
                        state      <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        // hand the next tie to the requester just served's peer
                        prio       <= ~grant_id;
                        state      <= IDLE;
                        if (grant_id) done_cnt1 <= done_cnt1 + 1'b1;
                        else          done_cnt0 <= done_cnt0 + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - scoreboard bench for alu_rr_scheduler with a behavioural ALU and requesters
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int DW = 16;
    localparam int OW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [OW-1:0] op;
    } req_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          busy;
    logic          grant_id;
    logic [CW-1:0] done_cnt0;
    logic [CW-1:0] done_cnt1;

    alu_rr_scheduler_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

    alu_rr_scheduler #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .busy      (busy),
        .grant_id  (grant_id),
        .done_cnt0 (done_cnt0),
        .done_cnt1 (done_cnt1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    req_t          rq0[$];
    req_t          rq1[$];
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    int            ord[$];
    int            acc_cyc[$];
    int            alu_hs_cyc;
    int            rsp_hs_cyc;
    logic [DW-1:0] last_alu_data;
    logic [OW-1:0] last_alu_op;

    int            alu_stall  = 0;
    int            rsp1_stall = 0;
    bit            alu_hold   = 1'b0;
    bit            alu_pending;
    logic [DW-1:0] alu_result;
    bit            p_alu_wait, p_rsp0_wait, p_rsp1_wait;
    logic [DW-1:0] p_alu_data, p_rsp0_data, p_rsp1_data;
    logic [OW-1:0] p_alu_op;

    // Reference ALU: opcode 1 sums nibbles, opcode 3 halves that sum, anything else adds the opcode
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] d, input logic [OW-1:0] op);
        logic [DW-1:0] s;
        s = DW'(d[3:0]) + DW'(d[7:4]) + DW'(d[11:8]) + DW'(d[15:12]);
        case (op)
            4'h1:    return s;
            4'h3:    return s >> 1;
            default: return d + DW'(op);
        endcase
    endfunction

    // Environment: drive on the falling edge, evaluate the coming rising-edge handshakes 1 ns later
    initial begin : env
        logic [DW-1:0] e;
        bus.req0_tvalid = 1'b0; bus.req0_tdata = '0; bus.req0_opcode = '0;
        bus.req1_tvalid = 1'b0; bus.req1_tdata = '0; bus.req1_opcode = '0;
        bus.alu_tready  = 1'b0;
        bus.res_tvalid  = 1'b0; bus.res_tdata = '0;
        bus.rsp0_tready = 1'b0; bus.rsp1_tready = 1'b0;
        alu_pending = 1'b0; alu_result = '0;
        p_alu_wait = 1'b0; p_rsp0_wait = 1'b0; p_rsp1_wait = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.req0_tvalid = rstn && (rq0.size() > 0);
            if (rq0.size() > 0) begin bus.req0_tdata = rq0[0].data; bus.req0_opcode = rq0[0].op; end
            bus.req1_tvalid = rstn && (rq1.size() > 0);
            if (rq1.size() > 0) begin bus.req1_tdata = rq1[0].data; bus.req1_opcode = rq1[0].op; end
            bus.alu_tready  = (alu_stall == 0);
            bus.res_tvalid  = alu_pending && !alu_hold;
            bus.res_tdata   = alu_result;
            bus.rsp0_tready = 1'b1;
            bus.rsp1_tready = (rsp1_stall == 0);
            #1;
            if (!rstn) begin
                alu_pending = 1'b0;
                p_alu_wait = 1'b0; p_rsp0_wait = 1'b0; p_rsp1_wait = 1'b0;
            end else begin
                if (bus.req0_tvalid && bus.req1_tvalid) begin
                    checks++;
                    if (bus.req0_tready && bus.req1_tready)
                        begin failures++; $display("FAIL both_tready: req0_tready=1 req1_tready=1 required at most one"); end
                end
                if (busy) begin
                    checks++;
                    if (bus.req0_tready || bus.req1_tready)
                        begin failures++; $display("FAIL tready_while_busy: req0_tready=%0b req1_tready=%0b required 0", bus.req0_tready, bus.req1_tready); end
                end
                if (p_alu_wait) begin
                    checks++;
                    if (!bus.alu_tvalid || bus.alu_tdata !== p_alu_data || bus.alu_opcode !== p_alu_op)
                        begin failures++; $display("FAIL alu_stable: valid=%0b data=%h op=%h required 1 %h %h", bus.alu_tvalid, bus.alu_tdata, bus.alu_opcode, p_alu_data, p_alu_op); end
                end
                if (p_rsp0_wait) begin
                    checks++;
                    if (!bus.rsp0_tvalid || bus.rsp0_tdata !== p_rsp0_data)
                        begin failures++; $display("FAIL rsp0_stable: valid=%0b data=%h required 1 %h", bus.rsp0_tvalid, bus.rsp0_tdata, p_rsp0_data); end
                end
                if (p_rsp1_wait) begin
                    checks++;
                    if (!bus.rsp1_tvalid || bus.rsp1_tdata !== p_rsp1_data)
                        begin failures++; $display("FAIL rsp1_stable: valid=%0b data=%h required 1 %h", bus.rsp1_tvalid, bus.rsp1_tdata, p_rsp1_data); end
                end
                if (bus.req0_tvalid && bus.req0_tready) begin void'(rq0.pop_front()); acc_cyc.push_back(cyc); end
                if (bus.req1_tvalid && bus.req1_tready) begin void'(rq1.pop_front()); acc_cyc.push_back(cyc); end
                if (bus.alu_tvalid && bus.alu_tready) begin
                    alu_pending   = 1'b1;
                    alu_result    = alu_fn(bus.alu_tdata, bus.alu_opcode);
                    alu_hs_cyc    = cyc;
                    last_alu_data = bus.alu_tdata;
                    last_alu_op   = bus.alu_opcode;
                end
                if (bus.res_tvalid && bus.res_tready) alu_pending = 1'b0;
                if (bus.rsp0_tvalid && bus.rsp0_tready) begin
                    checks++;
                    if (exp0.size() == 0) begin failures++; $display("FAIL rsp0_unexpected: data=%h required no response", bus.rsp0_tdata); end
                    else begin
                        e = exp0.pop_front();
                        if (bus.rsp0_tdata !== e) begin failures++; $display("FAIL rsp0_data: got %h required %h", bus.rsp0_tdata, e); end
                    end
                    ord.push_back(0); rsp_hs_cyc = cyc;
                end
                if (bus.rsp1_tvalid && bus.rsp1_tready) begin
                    checks++;
                    if (exp1.size() == 0) begin failures++; $display("FAIL rsp1_unexpected: data=%h required no response", bus.rsp1_tdata); end
                    else begin
                        e = exp1.pop_front();
                        if (bus.rsp1_tdata !== e) begin failures++; $display("FAIL rsp1_data: got %h required %h", bus.rsp1_tdata, e); end
                    end
                    ord.push_back(1); rsp_hs_cyc = cyc;
                end
                if (bus.alu_tvalid && alu_stall > 0) alu_stall--;
                if (bus.rsp1_tvalid && rsp1_stall > 0) rsp1_stall--;
                p_alu_wait  = bus.alu_tvalid && !bus.alu_tready;
                p_alu_data  = bus.alu_tdata;
                p_alu_op    = bus.alu_opcode;
                p_rsp0_wait = bus.rsp0_tvalid && !bus.rsp0_tready;
                p_rsp0_data = bus.rsp0_tdata;
                p_rsp1_wait = bus.rsp1_tvalid && !bus.rsp1_tready;
                p_rsp1_data = bus.rsp1_tdata;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        rstn = 1'b0;
        exp0.delete(); exp1.delete(); rq0.delete(); rq1.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #2;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (ord.size() < n && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        checks++;
        if (ord.size() < n) begin failures++; $display("FAIL %s_timeout: responses=%0d required=%0d", name, ord.size(), n); end
        @(negedge clk); #2;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk); #2;
        checks++;
        if ({busy, grant_id, bus.alu_tvalid, bus.res_tready, bus.rsp0_tvalid, bus.rsp1_tvalid} !== 6'b0)
            begin failures++; $display("FAIL reset_ctrl: busy=%0b gid=%0b alu_v=%0b res_r=%0b rsp0_v=%0b rsp1_v=%0b required 0", busy, grant_id, bus.alu_tvalid, bus.res_tready, bus.rsp0_tvalid, bus.rsp1_tvalid); end
        checks++;
        if ({bus.alu_tdata, bus.alu_opcode, bus.rsp0_tdata, bus.rsp1_tdata} !== '0)
            begin failures++; $display("FAIL reset_data: alu=%h op=%h rsp0=%h rsp1=%h required 0", bus.alu_tdata, bus.alu_opcode, bus.rsp0_tdata, bus.rsp1_tdata); end
        checks++;
        if (done_cnt0 !== 4'd0 || done_cnt1 !== 4'd0)
            begin failures++; $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d required 0 0", done_cnt0, done_cnt1); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #2;
    endtask

    task automatic test_single();
        ord.delete(); acc_cyc.delete();
        rq0.push_back('{data: 16'h1430, op: 4'h1});
        exp0.push_back(16'd8);
        wait_rsp(1, 30, "single");
        checks++;
        if (ord.size() != 1 || ord[0] != 0) begin failures++; $display("FAIL single_owner: responses=%0d first=%0d required 1 0", ord.size(), ord[0]); end
        checks++;
        if (last_alu_data !== 16'h1430 || last_alu_op !== 4'h1)
            begin failures++; $display("FAIL single_issue: data=%h op=%h required 1430 1", last_alu_data, last_alu_op); end
        checks++;
        if (acc_cyc.size() != 1 || alu_hs_cyc - acc_cyc[0] != 1 || rsp_hs_cyc - acc_cyc[0] != 3)
            begin failures++; $display("FAIL single_latency: alu=%0d rsp=%0d required 1 3", alu_hs_cyc - acc_cyc[0], rsp_hs_cyc - acc_cyc[0]); end
        checks++;
        if (done_cnt0 !== 4'd1 || done_cnt1 !== 4'd0)
            begin failures++; $display("FAIL single_cnt: cnt0=%0d cnt1=%0d required 1 0", done_cnt0, done_cnt1); end
    endtask

    task automatic test_tie(input string name);
        ord.delete(); acc_cyc.delete();
        rq0.push_back('{data: 16'h1430, op: 4'h1}); exp0.push_back(16'd8);
        rq1.push_back('{data: 16'h0420, op: 4'h3}); exp1.push_back(16'd3);
        wait_rsp(2, 40, name);
        checks++;
        if (ord.size() != 2 || ord[0] != 0 || ord[1] != 1)
            begin failures++; $display("FAIL %s_order: size=%0d first=%0d second=%0d required 2 0 1", name, ord.size(), ord[0], ord[1]); end
        checks++;
        if (done_cnt0 !== 4'd1 || done_cnt1 !== 4'd1)
            begin failures++; $display("FAIL %s_cnt: cnt0=%0d cnt1=%0d required 1 1", name, done_cnt0, done_cnt1); end
    endtask

    task automatic test_contention();
        req_t r;
        ord.delete(); acc_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            r = '{data: DW'($urandom), op: OW'($urandom_range(0, 15))};
            rq0.push_back(r); exp0.push_back(alu_fn(r.data, r.op));
            r = '{data: DW'($urandom), op: OW'($urandom_range(0, 15))};
            rq1.push_back(r); exp1.push_back(alu_fn(r.data, r.op));
        end
        wait_rsp(10, 100, "contention");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ord[i] != i % 2) begin failures++; $display("FAIL contention_order[%0d]: got %0d required %0d", i, ord[i], i % 2); end
        end
        for (int i = 1; i < 10; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 4)
                begin failures++; $display("FAIL contention_turnaround[%0d]: got %0d required 4", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
        checks++;
        if (done_cnt0 !== 4'd6 || done_cnt1 !== 4'd6)
            begin failures++; $display("FAIL contention_cnt: cnt0=%0d cnt1=%0d required 6 6", done_cnt0, done_cnt1); end
    endtask

    task automatic test_back_pressure();
        int k;
        ord.delete(); acc_cyc.delete();
        alu_stall = 5; rsp1_stall = 3;
        rq1.push_back('{data: 16'hBEEF, op: 4'h7}); exp1.push_back(alu_fn(16'hBEEF, 4'h7));
        k = 0;
        while (acc_cyc.size() < 1 && k < 20) begin @(negedge clk); #2; k++; end
        rq0.push_back('{data: 16'h0101, op: 4'h1}); exp0.push_back(16'd2);
        wait_rsp(2, 60, "backpressure");
        checks++;
        if (ord.size() != 2 || ord[0] != 1 || ord[1] != 0)
            begin failures++; $display("FAIL backpressure_order: size=%0d first=%0d second=%0d required 2 1 0", ord.size(), ord[0], ord[1]); end
        checks++;
        if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 12)
            begin failures++; $display("FAIL backpressure_turnaround: got %0d required 12", acc_cyc[1] - acc_cyc[0]); end
    endtask

    task automatic test_reset_mid();
        int k;
        ord.delete();
        alu_hold = 1'b1;
        rq0.push_back('{data: 16'h5555, op: 4'h2}); exp0.push_back(alu_fn(16'h5555, 4'h2));
        k = 0;
        while (!bus.res_tready && k < 20) begin @(negedge clk); #2; k++; end
        checks++;
        if (!bus.res_tready) begin failures++; $display("FAIL resetmid_reach: res_tready=0 required 1"); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, grant_id, bus.alu_tvalid, bus.res_tready, bus.rsp0_tvalid, bus.rsp1_tvalid} !== 6'b0)
            begin failures++; $display("FAIL resetmid_ctrl: busy=%0b gid=%0b alu_v=%0b res_r=%0b rsp0_v=%0b rsp1_v=%0b required 0", busy, grant_id, bus.alu_tvalid, bus.res_tready, bus.rsp0_tvalid, bus.rsp1_tvalid); end
        checks++;
        if (done_cnt0 !== 4'd0 || done_cnt1 !== 4'd0 || bus.alu_tdata !== 16'h0)
            begin failures++; $display("FAIL resetmid_regs: cnt0=%0d cnt1=%0d alu=%h required 0 0 0", done_cnt0, done_cnt1, bus.alu_tdata); end
        exp0.delete();
        alu_hold = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (ord.size() != 0) begin failures++; $display("FAIL resetmid_norsp: responses=%0d required 0", ord.size()); end
        test_tie("resetmid_tie");
    endtask

    task automatic test_counter_wrap();
        do_reset();
        ord.delete();
        for (int i = 0; i < 17; i++) begin
            rq1.push_back('{data: DW'(i * 16'h0111), op: 4'h1});
            exp1.push_back(alu_fn(DW'(i * 16'h0111), 4'h1));
        end
        wait_rsp(17, 150, "wrap");
        checks++;
        if (done_cnt1 !== 4'd1 || done_cnt0 !== 4'd0)
            begin failures++; $display("FAIL wrap_cnt: cnt0=%0d cnt1=%0d required 0 1", done_cnt0, done_cnt1); end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_single();
        do_reset();
        test_tie("tie");
        test_contention();
        test_back_pressure();
        test_reset_mid();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
